// File: rtl/instruction_fetch.sv
// Fetch stage: owns the word-addressed PC, drives a 1-cycle-latency instruction RAM,
// and presents a registered instr/PC pair to decode with stall replay, redirect and halt.
module instruction_fetch #(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mode_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_out_t;

  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  fetch_out_t        out_q, out_d;

  // Address port: a stalled in-flight read is replayed so its word is still
  // on imem_data when decode finally accepts it.
  always_comb begin
    imem_addr = pc_q;
    if (rst)
      imem_addr = RESET_PC;
    else if (mode_q == HALTED)
      imem_addr = pc_q;
    else if (redirect_valid)
      imem_addr = redirect_pc;
    else if (stall && infl_q)
      imem_addr = infl_pc_q;
  end

  // Next-state: redirect > halt > stall > normal; nothing moves once halted.
  always_comb begin
    mode_d    = mode_q;
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    out_d     = out_q;
    if (mode_q == RUN) begin
      if (redirect_valid) begin
        out_d.vld = 1'b0;
        infl_d    = 1'b1;
        infl_pc_d = redirect_pc;
        pc_d      = redirect_pc + ADDR_W'(1);
      end else if (halt) begin
        mode_d    = HALTED;
        out_d.vld = 1'b0;
        infl_d    = 1'b0;
      end else if (!stall) begin
        infl_d    = 1'b1;
        infl_pc_d = pc_q;
        pc_d      = pc_q + ADDR_W'(1);
        out_d.vld = infl_q;
        // Only capture data that belongs to a real read, so X never leaks out.
        if (infl_q) begin
          out_d.instr = imem_data;
          out_d.pc    = infl_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= RUN;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      out_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      out_q     <= out_d;
    end
  end

  assign instr_valid = out_q.vld;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;
  assign halted      = (mode_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural RAM, stream-level reference model,
// directed scenarios plus a randomized stall/redirect/halt/reset run.
module tb_instruction_fetch;
  localparam int          AW  = 11;
  localparam int          DW  = 32;
  localparam logic [AW-1:0] RPC = '0;

  logic          clk = 1'b0;
  logic          rst, stall, redirect_valid, halt;
  logic [AW-1:0] redirect_pc, imem_addr, instr_pc;
  logic [DW-1:0] imem_data, instr;
  logic          instr_valid, halted;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0;
  int bad   = 0;
  logic [AW-1:0] addr_seen;

  // Reference: stream of delivered addresses. m_wait counts accepted cycles
  // still needed before the next word appears; m_nxt is that word's address.
  logic          m_valid, m_halted;
  logic [AW-1:0] m_pc, m_nxt;
  int            m_wait;

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return 32'hA000_0000 + {21'd0, a};
  endfunction

  task automatic model_edge(input logic r, st, rv, input logic [AW-1:0] rp, input logic h);
    if (r) begin
      m_valid = 0; m_pc = '0; m_halted = 0; m_nxt = RPC; m_wait = 1;
    end else if (m_halted) begin
    end else if (rv) begin
      m_valid = 0; m_nxt = rp; m_wait = 0;
    end else if (h) begin
      m_halted = 1; m_valid = 0;
    end else if (st) begin
    end else if (m_wait > 0) begin
      m_wait--; m_valid = 0;
    end else begin
      m_valid = 1; m_pc = m_nxt; m_nxt = m_nxt + 1'b1;
    end
  endtask

  // One clock: drive at negedge, capture imem_addr, clock, sample at next negedge.
  task automatic step(input logic r, st, rv, input logic [AW-1:0] rp, input logic h);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rp; halt = h;
    #1 addr_seen = imem_addr;
    @(posedge clk);
    model_edge(r, st, rv, rp, h);
    @(negedge clk);
  endtask

  task automatic run_to(input logic [AW-1:0] target);
    int n = 0;
    while (!(instr_valid && instr_pc == target) && n < 60) begin
      step(0, 0, 0, '0, 0);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL run_to: instr_pc=%0d never reached %0d", instr_pc, target);
    end
  endtask

  task automatic test_reset;
    step(1, 0, 0, 11'd55, 0);
    total++;
    if (addr_seen !== RPC) begin bad++; $display("FAIL reset_addr: got %0d want %0d", addr_seen, RPC); end
    step(1, 1, 1, 11'd77, 1);
    total++;
    if ({instr_valid, halted, instr, instr_pc} !== {2'b00, 32'd0, 11'd0}) begin
      bad++;
      $display("FAIL reset_state: v=%b h=%b instr=%h pc=%0d want all zero", instr_valid, halted, instr, instr_pc);
    end
  endtask

  task automatic test_sequential;
    step(1, 0, 0, '0, 0);
    for (int k = 1; k <= 34; k++) begin
      step(0, 0, 0, '0, 0);
      if (k <= 3) begin
        total++;
        if (addr_seen !== AW'(k - 1)) begin bad++; $display("FAIL seq_addr: got %0d want %0d", addr_seen, k - 1); end
      end
      total++;
      if (instr_valid !== (k >= 2)) begin
        bad++; $display("FAIL seq_valid: cycle %0d got %b want %b", k, instr_valid, k >= 2);
      end else if (k >= 2 && (instr_pc !== AW'(k - 2) || instr !== word(AW'(k - 2)))) begin
        bad++; $display("FAIL seq_data: got (%h,%0d) want (%h,%0d)", instr, instr_pc, word(AW'(k - 2)), k - 2);
      end
    end
  endtask

  task automatic test_stall;
    step(1, 0, 0, '0, 0);
    run_to(11'd5);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0, 0);
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, word(11'd5), 11'd5}) begin
        bad++; $display("FAIL stall_hold: got v=%b (%h,%0d) want (%h,5)", instr_valid, instr, instr_pc, word(11'd5));
      end
    end
    for (int p = 6; p <= 7; p++) begin
      step(0, 0, 0, '0, 0);
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, word(AW'(p)), AW'(p)}) begin
        bad++; $display("FAIL stall_resume: got v=%b (%h,%0d) want %0d", instr_valid, instr, instr_pc, p);
      end
    end
  endtask

  task automatic test_redirect;
    logic seen8 = 0;
    step(1, 0, 0, '0, 0);
    run_to(11'd7);
    step(0, 0, 1, 11'd100, 0);
    total++;
    if (addr_seen !== 11'd100) begin bad++; $display("FAIL redir_addr: got %0d want 100", addr_seen); end
    total++;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble: valid=%b want 0", instr_valid); end
    for (int p = 100; p <= 102; p++) begin
      step(0, 0, 0, '0, 0);
      if (instr_valid && instr_pc == 11'd8) seen8 = 1;
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, word(AW'(p)), AW'(p)}) begin
        bad++; $display("FAIL redir_target: got v=%b (%h,%0d) want %0d", instr_valid, instr, instr_pc, p);
      end
    end
    total++;
    if (seen8) begin bad++; $display("FAIL redir_squash: wrong-path word 8 got delivered"); end
  endtask

  task automatic test_combo;
    step(1, 0, 0, '0, 0);
    run_to(11'd4);
    step(0, 1, 1, 11'd20, 1);
    total++;
    if ({addr_seen, instr_valid, halted} !== {11'd20, 2'b00}) begin
      bad++; $display("FAIL combo: addr=%0d v=%b h=%b want 20,0,0", addr_seen, instr_valid, halted);
    end
    step(0, 0, 0, '0, 0);
    total++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, word(11'd20), 11'd20}) begin
      bad++; $display("FAIL combo_resume: got v=%b (%h,%0d) want 20", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_halt;
    step(1, 0, 0, '0, 0);
    run_to(11'd10);
    step(0, 0, 0, '0, 1);
    total++;
    if ({halted, instr_valid} !== 2'b10) begin bad++; $display("FAIL halt_enter: h=%b v=%b want 1,0", halted, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 11'd300, 0);
      total++;
      if ({addr_seen, halted, instr_valid} !== {11'd12, 2'b10}) begin
        bad++; $display("FAIL halt_frozen: addr=%0d h=%b v=%b want 12,1,0", addr_seen, halted, instr_valid);
      end
    end
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    total++;
    if ({halted, instr_valid, instr_pc, instr} !== {2'b01, RPC, word(RPC)}) begin
      bad++; $display("FAIL halt_reset: h=%b v=%b pc=%0d want 0,1,%0d", halted, instr_valid, instr_pc, RPC);
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_pc [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 11'd2046, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, 0);
      total++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, word(exp_pc[i]), exp_pc[i]}) begin
        bad++; $display("FAIL wrap: got v=%b (%h,%0d) want %0d", instr_valid, instr, instr_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_random;
    int hcnt = 0;
    logic r, st, rv, h;
    logic [AW-1:0] rp;
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) < 1) || (m_halted && ++hcnt > 4);
      if (r) hcnt = 0;
      st = $urandom_range(99) < 30;
      rv = $urandom_range(99) < 6;
      h  = $urandom_range(99) < 2;
      rp = AW'($urandom);
      step(r, st, rv, rp, h);
      if (!r && rv && !halted) begin
        total++;
        if (addr_seen !== rp) begin bad++; $display("FAIL rnd_addr: got %0d want %0d", addr_seen, rp); end
      end
      total++;
      if (instr_valid !== m_valid || halted !== m_halted) begin
        bad++; $display("FAIL rnd_ctrl: cyc %0d v=%b h=%b want v=%b h=%b", i, instr_valid, halted, m_valid, m_halted);
      end else if (m_valid && (instr_pc !== m_pc || instr !== word(m_pc))) begin
        bad++; $display("FAIL rnd_data: cyc %0d got (%h,%0d) want (%h,%0d)", i, instr, instr_pc, word(m_pc), m_pc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = word(AW'(i));
    imem_data = '0;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = '0; halt = 0;
    m_valid = 0; m_halted = 0; m_pc = '0; m_nxt = RPC; m_wait = 1;
    @(negedge clk);
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_combo;
    test_halt;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the KGP-miniRISC core. Sits directly upstream of the InstructionMemory block RAM: drives its address port and consumes its read data.
- Memory read is synchronous with 1-cycle latency: address presented in cycle t, data valid in cycle t+1.
- Owns the program counter (word-addressed). Handles sequential fetch, stall replay, branch/jump redirect with squash, and halt.
- Presents a registered instruction/PC pair to decode.

Parameters:
- ADDR_W, 11, instruction word-address width; matches the memory address port.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  core clock; also drives the memory clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept a new instruction this cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  ADDR_W  target word address.
- halt  in  1  decode has seen a halt instruction.
- imem_addr  out  ADDR_W  to memory address port.
- imem_data  in  DATA_W  from memory data port.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  address of instr.
- halted  out  1  fetch has stopped permanently until reset.

Behaviour:
- State registers: pc_q (next address to issue), infl_q / infl_pc_q (one read in flight and its address), output registers, halted_q.
- Priority order per edge: rst > redirect_valid > halt > stall > normal.
- Reset (sync):
  - pc_q=RESET_PC, infl_q=0, infl_pc_q=0.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
  - imem_addr=RESET_PC while rst is high.
- imem_addr (combinational):
  - redirect_valid: redirect_pc.
  - else stall && infl_q: infl_pc_q (replay the in-flight address so its word is re-read next cycle).
  - else: pc_q.
- Normal (no rst/redirect/halt/stall, not halted):
  - infl_q<=1, infl_pc_q<=pc_q, pc_q<=pc_q+1.
  - If infl_q: instr<=imem_data, instr_pc<=infl_pc_q, instr_valid<=1; else instr_valid<=0.
- Latency: address issued in cycle t; instruction visible on the outputs in cycle t+2.
  - After reset release, first valid at cycle 2. Steady state: one instruction per cycle.
- Stall:
  - All registers hold, including the output registers, which stay stable.
  - The replayed address makes imem_data equal mem[infl_pc_q] in the cycle after stall drops, so no word is lost or duplicated.
  - Stall lasting N cycles yields an identical output sequence, shifted by N.
- Redirect (overrides stall and halt):
  - instr_valid<=0 (squash the wrong-path word and any in-flight word).
  - infl_q<=1, infl_pc_q<=redirect_pc, pc_q<=redirect_pc+1.
  - Target appears valid 2 cycles after the redirect cycle, giving exactly one bubble cycle.
- Halt:
  - halted<=1, instr_valid<=0, infl_q<=0. pc_q holds.
  - While halted: no state changes, imem_addr=pc_q, instr_valid=0.
  - redirect_valid still wins in the cycle halt is asserted. Once halted=1, redirect is ignored; only rst clears halted.
- Address arithmetic: unsigned, modulo 2^ADDR_W. pc_q=2047 increments to 0; redirect_pc=2047 is followed by a fetch of 0.
- Reset mid-stall or mid-redirect: reset wins, and all in-flight state is discarded.
- Simultaneous stall and redirect: redirect is taken, and the output registers are cleared even though stall is high.
- No X-propagation: instr is not loaded when infl_q=0.

Test Plan:
- Sequential fetch: memory preloaded mem[i]=0xA0000000+i; release rst at cycle 0 -> imem_addr 0,1,2..., instr_valid rises at cycle 2; instr/instr_pc = (0xA0000000,0), (0xA0000001,1), ... one per cycle for 32 words.
- Stall replay: stall high for 3 cycles while instr_pc=5 -> outputs held at (0xA0000005,5) for those cycles; after release the next outputs are 6, 7, with none skipped or duplicated.
- Redirect: redirect_valid=1, redirect_pc=100 while instr_pc=7 -> imem_addr=100 that cycle, instr_valid=0 the next cycle, then instr_pc 100, 101, ...; word 8 never appears valid.
- Redirect+stall+halt same cycle, target 20 -> redirect taken, halted stays 0, fetch resumes at 20.
- Halt: halt=1 at instr_pc=10 -> halted=1 and instr_valid=0 next cycle; imem_addr frozen; a later redirect has no effect; rst returns to a fetch from RESET_PC.
- Wrap: redirect_pc=2046 -> instr_pc sequence 2046, 2047, 0, 1, with valid held high.
